// File: rtl/custom_instruction_arbiter.sv
// Round-robin arbiter sharing one custom-instruction accelerator between CPU_COUNT CPU ports.
// One command is outstanding at a time; the grant is held until the response handshake completes.
module custom_instruction_arbiter #(
  parameter int CPU_COUNT = 4,
  parameter int FUNC_W    = 10,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CPU_COUNT-1:0]        req_cmd_valid,
  output logic [CPU_COUNT-1:0]        req_cmd_ready,
  input  logic [CPU_COUNT*FUNC_W-1:0] req_function_id,
  input  logic [CPU_COUNT*DATA_W-1:0] req_inputs_0,
  input  logic [CPU_COUNT*DATA_W-1:0] req_inputs_1,
  output logic [CPU_COUNT-1:0]        req_rsp_valid,
  input  logic [CPU_COUNT-1:0]        req_rsp_ready,
  output logic [CPU_COUNT*DATA_W-1:0] req_outputs_0,
  output logic                        acc_cmd_valid,
  input  logic                        acc_cmd_ready,
  output logic [FUNC_W-1:0]           acc_function_id,
  output logic [DATA_W-1:0]           acc_inputs_0,
  output logic [DATA_W-1:0]           acc_inputs_1,
  input  logic                        acc_rsp_valid,
  output logic                        acc_rsp_ready,
  input  logic [DATA_W-1:0]           acc_outputs_0,
  output logic                        busy,
  output logic [2:0]                  owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [2:0]             owner_r;
  logic [2:0]             owner_nxt_s;
  logic [2:0]             rr_ptr_r;
  logic [2:0]             rr_ptr_nxt_s;
  logic [2:0]             rr_after_s;
  logic [CPU_COUNT-1:0]   owner_oh_s;
  logic                   owner_cmd_valid_s;
  logic                   owner_rsp_ready_s;
  logic                   rsp_done_s;

  // First requester found scanning upward from ptr, wrapping modulo CPU_COUNT.
  function automatic logic [2:0] rr_pick(input logic [CPU_COUNT-1:0] vld, input logic [2:0] ptr);
    logic [2*CPU_COUNT-1:0] rot;
    logic [2:0]             sel;
    int                     idx;
    rot = {vld, vld} >> ptr;
    sel = 3'd0;
    for (int k = CPU_COUNT - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % CPU_COUNT;
      sel = ((rot & ((2*CPU_COUNT)'(1'b1) << k)) != '0) ? 3'(idx) : sel;
    end
    return sel;
  endfunction

  assign owner_oh_s        = CPU_COUNT'(1'b1) << owner_r;
  assign owner_cmd_valid_s = |(req_cmd_valid & owner_oh_s);
  assign owner_rsp_ready_s = |(req_rsp_ready & owner_oh_s);
  assign rsp_done_s        = acc_rsp_valid & owner_rsp_ready_s;
  assign rr_after_s        = (owner_r == 3'(CPU_COUNT - 1)) ? 3'd0 : owner_r + 3'd1;
  assign req_outputs_0     = {CPU_COUNT{acc_outputs_0}};
  assign busy              = (state_r != IDLE);
  assign owner             = owner_r;

  // State, grant owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      owner_r  <= 3'd0;
      rr_ptr_r <= 3'd0;
    end else begin
      state_r  <= state_nxt_s;
      owner_r  <= owner_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

  // Next-state logic and handshake routing between the owner and the accelerator.
  always_comb begin
    state_nxt_s   = state_r;
    owner_nxt_s   = owner_r;
    rr_ptr_nxt_s  = rr_ptr_r;
    req_cmd_ready = '0;
    req_rsp_valid = '0;
    acc_cmd_valid = 1'b0;
    acc_rsp_ready = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req_cmd_valid) begin
          owner_nxt_s = rr_pick(req_cmd_valid, rr_ptr_r);
          state_nxt_s = CMD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CMD: begin
        acc_cmd_valid = owner_cmd_valid_s;
        req_cmd_ready = owner_oh_s & {CPU_COUNT{acc_cmd_ready}};
        req_rsp_valid = owner_oh_s & {CPU_COUNT{acc_rsp_valid}};
        acc_rsp_ready = owner_rsp_ready_s;
        // A withdrawn command forfeits the grant without advancing the pointer.
        if (!owner_cmd_valid_s) begin
          state_nxt_s = IDLE;
        end else if (acc_cmd_ready) begin
          if (rsp_done_s) begin
            state_nxt_s  = IDLE;
            rr_ptr_nxt_s = rr_after_s;
          end else begin
            state_nxt_s = RSP;
          end
        end else begin
          state_nxt_s = CMD;
        end
      end
      RSP: begin
        req_rsp_valid = owner_oh_s & {CPU_COUNT{acc_rsp_valid}};
        acc_rsp_ready = owner_rsp_ready_s;
        if (rsp_done_s) begin
          state_nxt_s  = IDLE;
          rr_ptr_nxt_s = rr_after_s;
        end else begin
          state_nxt_s = RSP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Command fields follow the owner's slice regardless of acc_cmd_valid.
  always_comb begin
    acc_function_id = req_function_id[FUNC_W-1:0];
    acc_inputs_0    = req_inputs_0[DATA_W-1:0];
    acc_inputs_1    = req_inputs_1[DATA_W-1:0];
    for (int k = 1; k < CPU_COUNT; k++) begin
      acc_function_id = (owner_r == 3'(k)) ? req_function_id[k*FUNC_W +: FUNC_W] : acc_function_id;
      acc_inputs_0    = (owner_r == 3'(k)) ? req_inputs_0[k*DATA_W +: DATA_W]    : acc_inputs_0;
      acc_inputs_1    = (owner_r == 3'(k)) ? req_inputs_1[k*DATA_W +: DATA_W]    : acc_inputs_1;
    end
  end

endmodule

// File: tb/tb_custom_instruction_arbiter.sv
// Self-checking bench for custom_instruction_arbiter: a transaction-level model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_custom_instruction_arbiter;
  localparam int N  = 4;
  localparam int FW = 10;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_cmd_valid, req_cmd_ready, req_rsp_valid, req_rsp_ready;
  logic [N*FW-1:0] req_function_id;
  logic [N*DW-1:0] req_inputs_0, req_inputs_1, req_outputs_0;
  logic            acc_cmd_valid, acc_cmd_ready, acc_rsp_valid, acc_rsp_ready, busy;
  logic [FW-1:0]   acc_function_id;
  logic [DW-1:0]   acc_inputs_0, acc_inputs_1, acc_outputs_0;
  logic [2:0]      owner;

  always #5 clk = ~clk;

  custom_instruction_arbiter #(.CPU_COUNT(N), .FUNC_W(FW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_cmd_valid(req_cmd_valid), .req_cmd_ready(req_cmd_ready),
    .req_function_id(req_function_id), .req_inputs_0(req_inputs_0), .req_inputs_1(req_inputs_1),
    .req_rsp_valid(req_rsp_valid), .req_rsp_ready(req_rsp_ready), .req_outputs_0(req_outputs_0),
    .acc_cmd_valid(acc_cmd_valid), .acc_cmd_ready(acc_cmd_ready),
    .acc_function_id(acc_function_id), .acc_inputs_0(acc_inputs_0), .acc_inputs_1(acc_inputs_1),
    .acc_rsp_valid(acc_rsp_valid), .acc_rsp_ready(acc_rsp_ready), .acc_outputs_0(acc_outputs_0),
    .busy(busy), .owner(owner)
  );

  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: is a transaction open, has its command been accepted, who owns it,
  // and where the next fair search starts.
  logic       m_active = 1'b0, m_accepted = 1'b0;
  logic [1:0] m_owner = 2'd0, m_next = 2'd0;
  logic [1:0] m_grants[$];

  function automatic logic [1:0] pick(input logic [3:0] v, input logic [1:0] start);
    logic [1:0] c, sel;
    logic       found;
    sel = start;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = start + 2'(k);
      if (!found && v[c]) begin
        sel = c;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  wire own_cmd_v   = req_cmd_valid[m_owner];
  wire own_rsp_rdy = req_rsp_ready[m_owner];
  wire rsp_hs      = acc_rsp_valid && own_rsp_rdy;

  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0; m_accepted <= 1'b0; m_next <= 2'd0;
    end else if (!m_active) begin
      if (req_cmd_valid != 4'b0) begin
        m_owner <= pick(req_cmd_valid, m_next);
        m_active <= 1'b1; m_accepted <= 1'b0;
        m_grants.push_back(pick(req_cmd_valid, m_next));
      end
    end else if (!m_accepted) begin
      if (!own_cmd_v) m_active <= 1'b0;
      else if (acc_cmd_ready) begin
        if (rsp_hs) begin m_active <= 1'b0; m_next <= m_owner + 2'd1; end
        else m_accepted <= 1'b1;
      end
    end else if (rsp_hs) begin
      m_active <= 1'b0; m_next <= m_owner + 2'd1;
    end
  end

  wire [3:0] m_oh              = 4'b0001 << m_owner;
  wire       in_cmd            = m_active && !m_accepted;
  wire [3:0] exp_cmd_ready     = (in_cmd && acc_cmd_ready) ? m_oh : 4'b0;
  wire       exp_acc_cmd_valid = in_cmd && own_cmd_v;
  wire [3:0] exp_rsp_valid     = (m_active && acc_rsp_valid) ? m_oh : 4'b0;
  wire       exp_acc_rsp_ready = m_active && own_rsp_rdy;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_active);
      chk("req_cmd_ready", req_cmd_ready, exp_cmd_ready);
      chk("acc_cmd_valid", acc_cmd_valid, exp_acc_cmd_valid);
      chk("req_rsp_valid", req_rsp_valid, exp_rsp_valid);
      chk("acc_rsp_ready", acc_rsp_ready, exp_acc_rsp_ready);
      chk("req_outputs_0", req_outputs_0, {N{acc_outputs_0}});
      if (m_active) chk("owner", owner, {1'b0, m_owner});
      if (exp_acc_cmd_valid) begin
        chk("acc_function_id", acc_function_id, req_function_id[int'(m_owner)*FW +: FW]);
        chk("acc_inputs_0", acc_inputs_0, req_inputs_0[int'(m_owner)*DW +: DW]);
        chk("acc_inputs_1", acc_inputs_1, req_inputs_1[int'(m_owner)*DW +: DW]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays a 2-cycle-latency accelerator for one transaction; returns the owner seen at the grant.
  task automatic serve(input logic [31:0] result, output logic [2:0] got);
    int n = 0;
    while (!acc_cmd_valid && n < 10) begin tick(); n++; end
    chk("grant_wait", acc_cmd_valid, 1'b1);
    got = owner;
    acc_cmd_ready = 1'b1;
    tick();
    acc_cmd_ready = 1'b0;
    tick();
    acc_rsp_valid = 1'b1; acc_outputs_0 = result;
    tick();
    acc_rsp_valid = 1'b0;
  endtask

  logic [2:0] exp_ord [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
  logic [2:0] got;

  initial begin
    reset = 1'b1; req_cmd_valid = '0; req_rsp_ready = '0; req_function_id = '0;
    req_inputs_0 = '0; req_inputs_1 = '0; acc_cmd_ready = 1'b0; acc_rsp_valid = 1'b0;
    acc_outputs_0 = '0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_owner", owner, 3'd0);
    chk("reset_acc_cmd_valid", acc_cmd_valid, 1'b0);
    chk("reset_acc_rsp_ready", acc_rsp_ready, 1'b0);
    reset = 1'b0;

    // Single request from CPU2
    req_function_id[2*FW +: FW] = 10'h005;
    req_inputs_0[2*DW +: DW] = 32'h1122_3344;
    req_inputs_1[2*DW +: DW] = 32'hAABB_CCDD;
    req_cmd_valid = 4'b0100; req_rsp_ready = 4'b1111; acc_cmd_ready = 1'b1;
    #1;
    chk("t1_no_cmd_in_idle", acc_cmd_valid, 1'b0);
    tick();
    chk("t1_acc_cmd_valid", acc_cmd_valid, 1'b1);
    chk("t1_fid", acc_function_id, 10'h005);
    chk("t1_in0", acc_inputs_0, 32'h1122_3344);
    chk("t1_in1", acc_inputs_1, 32'hAABB_CCDD);
    chk("t1_cmd_ready", req_cmd_ready, 4'b0100);
    tick();
    req_cmd_valid = 4'b0000; acc_cmd_ready = 1'b0;
    tick(); tick();
    acc_rsp_valid = 1'b1; acc_outputs_0 = 32'hDEAD_BEEF;
    #1;
    chk("t1_rsp_valid", req_rsp_valid, 4'b0100);
    chk("t1_out_slice2", req_outputs_0[2*DW +: DW], 32'hDEAD_BEEF);
    chk("t1_busy_before", busy, 1'b1);
    tick();
    acc_rsp_valid = 1'b0;
    chk("t1_busy_after", busy, 1'b0);

    // All CPUs requesting continuously from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_grants.delete();
    for (int i = 0; i < N; i++) begin
      req_function_id[i*FW +: FW] = 10'(256 + i);
      req_inputs_0[i*DW +: DW] = 32'h1000_0000 + 32'(i);
      req_inputs_1[i*DW +: DW] = 32'h2000_0000 + 32'(i);
    end
    req_cmd_valid = 4'b1111;
    for (int t = 0; t < 6; t++) begin
      serve(32'h5000_0000 + 32'(t), got);
      chk("t2_grant_order", got, exp_ord[t]);
    end
    chk("t2_model_grants", 32'(m_grants.size()), 32'd6);
    for (int t = 0; t < 6 && t < m_grants.size(); t++) chk("t2_model_order", m_grants[t], exp_ord[t][1:0]);

    // Back-pressure on command then response; pointer now at 2, CPU1 and CPU3 request
    req_cmd_valid = 4'b1010;
    tick();
    chk("t3_owner", owner, 3'd3);
    for (int c = 0; c < 5; c++) begin
      chk("t3_in0_stable", acc_inputs_0, 32'h1000_0003);
      chk("t3_cmd_ready_low", req_cmd_ready, 4'b0000);
      tick();
    end
    acc_cmd_ready = 1'b1;
    tick();
    acc_cmd_ready = 1'b0; req_cmd_valid = 4'b0010;
    acc_rsp_valid = 1'b1; acc_outputs_0 = 32'h0BAD_F00D; req_rsp_ready = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t3_rsp_valid_held", req_rsp_valid, 4'b1000);
      chk("t3_owner_held", owner, 3'd3);
      tick();
    end
    req_rsp_ready = 4'b1111;
    tick();
    acc_rsp_valid = 1'b0;
    chk("t3_idle_after", busy, 1'b0);
    tick();
    chk("t3_next_grant", owner, 3'd1);

    // Command and response handshake in the same cycle
    acc_cmd_ready = 1'b1; acc_rsp_valid = 1'b1; acc_outputs_0 = 32'hCAFE_F00D;
    #1;
    chk("t4_rsp_valid", req_rsp_valid, 4'b0010);
    chk("t4_cmd_ready", req_cmd_ready, 4'b0010);
    tick();
    req_cmd_valid = 4'b0000; acc_cmd_ready = 1'b0; acc_rsp_valid = 1'b0;
    chk("t4_idle", busy, 1'b0);

    // Reset while CPU1 waits for its response, CPU3 pending
    req_cmd_valid = 4'b0010;
    tick();
    chk("t5_owner1", owner, 3'd1);
    acc_cmd_ready = 1'b1;
    tick();
    acc_cmd_ready = 1'b0; req_cmd_valid = 4'b1000;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; acc_rsp_valid = 1'b1;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_owner0", owner, 3'd0);
    chk("t5_rsp_hidden", req_rsp_valid, 4'b0000);
    chk("t5_acc_rsp_ready", acc_rsp_ready, 1'b0);
    chk("t5_cmd_ready", req_cmd_ready, 4'b0000);
    tick();
    acc_rsp_valid = 1'b0;
    chk("t5_cpu3_granted", owner, 3'd3);
    acc_cmd_ready = 1'b1;
    tick();
    acc_cmd_ready = 1'b0; req_cmd_valid = 4'b0000; acc_rsp_valid = 1'b1;
    tick();
    acc_rsp_valid = 1'b0;

    // Withdrawn request keeps the pointer where it was
    req_cmd_valid = 4'b0101;
    tick();
    chk("t6_owner0", owner, 3'd0);
    req_cmd_valid = 4'b0100;
    #1;
    chk("t6_cmd_dropped", acc_cmd_valid, 1'b0);
    tick();
    chk("t6_idle", busy, 1'b0);
    req_cmd_valid = 4'b0101;
    tick();
    chk("t6_regrant0", owner, 3'd0);
    req_cmd_valid = 4'b0000;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/custom_instruction_arbiter.md
Name: custom_instruction_arbiter

Overview:
- Shares one custom-instruction accelerator (e.g. aes_instruction) between CPU_COUNT CPU custom-instruction ports.
- Sits between the SoC's cpuN_customInstruction_* buses and a single accelerator instance.
- Round-robin arbitration with one outstanding command; the grant is held until the response handshake completes.
- Each response is routed back to the CPU that issued the command.

Parameters:
- CPU_COUNT, 4, number of requesting CPU ports (1..8).
- FUNC_W, 10, function_id width.
- DATA_W, 32, operand/result width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_cmd_valid  in  CPU_COUNT  per-CPU command valid.
- req_cmd_ready  out  CPU_COUNT  per-CPU command accept.
- req_function_id  in  CPU_COUNT*FUNC_W  packed, CPU i at [i*FUNC_W +: FUNC_W].
- req_inputs_0  in  CPU_COUNT*DATA_W  packed operand 0.
- req_inputs_1  in  CPU_COUNT*DATA_W  packed operand 1.
- req_rsp_valid  out  CPU_COUNT  per-CPU response valid.
- req_rsp_ready  in  CPU_COUNT  per-CPU response ready.
- req_outputs_0  out  CPU_COUNT*DATA_W  packed result; every slice carries acc_outputs_0.
- acc_cmd_valid  out  1  to accelerator.
- acc_cmd_ready  in  1  from accelerator.
- acc_function_id  out  FUNC_W  granted CPU's function_id.
- acc_inputs_0  out  DATA_W  granted CPU's operand 0.
- acc_inputs_1  out  DATA_W  granted CPU's operand 1.
- acc_rsp_valid  in  1  from accelerator.
- acc_rsp_ready  out  1  to accelerator.
- acc_outputs_0  in  DATA_W  accelerator result.
- busy  out  1  high when state != IDLE.
- owner  out  3  index of the granted CPU; valid when busy.

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-high.
  - On reset: state=IDLE, owner=0, rr_ptr=0.
  - All outputs low: req_cmd_ready=0, req_rsp_valid=0, acc_cmd_valid=0, acc_rsp_ready=0, busy=0.
  - Reset mid-transaction abandons the transaction; no response is delivered.
- States: IDLE, CMD, RSP.
- IDLE:
  - If any req_cmd_valid is set, pick the first set bit searching from rr_ptr upward, wrapping modulo CPU_COUNT.
  - Register owner and go to CMD. No outputs are asserted in IDLE.
  - Latency: request seen in cycle n -> acc_cmd_valid high in cycle n+1.
- CMD:
  - acc_cmd_valid = req_cmd_valid[owner].
  - acc_function_id/inputs are combinationally muxed from owner's slice.
  - req_cmd_ready[owner] = acc_cmd_ready. All other req_cmd_ready bits stay 0.
  - If req_cmd_valid[owner] drops before the handshake (protocol violation), return to IDLE without updating rr_ptr.
  - On handshake (acc_cmd_valid & acc_cmd_ready):
    - Go to RSP.
    - Exception: if acc_rsp_valid & req_rsp_ready[owner] in the same cycle, the response completes too; go to IDLE.
- RSP, and CMD for the response path:
  - req_rsp_valid[owner] = acc_rsp_valid; other bits 0.
  - acc_rsp_ready = req_rsp_ready[owner].
  - On response handshake: rr_ptr = (owner+1) mod CPU_COUNT; go to IDLE.
- A non-owner acc_rsp_valid is never visible to any CPU outside CMD/RSP. In IDLE, acc_rsp_ready=0.
- Fairness:
  - Minimum 1 idle cycle between transactions.
  - With all CPUs requesting continuously, grants rotate 0,1,..,CPU_COUNT-1,0.
  - A waiting CPU is granted within CPU_COUNT-1 transactions.
- CPU_COUNT=1: owner is always 0; behaviour is identical apart from arbitration.
- Data outputs (acc_function_id, acc_inputs_*) are don't-care when acc_cmd_valid=0. They are driven from owner's slice; they are not zeroed.

Test Plan:
- Single request: CPU2 cmd_valid, fid=0x005, in0=0x11223344, in1=0xAABBCCDD, acc_cmd_ready=1. Accelerator returns rsp 3 cycles later with outputs=0xDEADBEEF.
  -> acc_cmd_valid asserted 1 cycle after the request, carrying CPU2's fields.
  -> Only req_rsp_valid[2] rises; req_outputs_0 slice 2 = 0xDEADBEEF.
  -> busy falls the cycle after the rsp handshake.
- All 4 CPUs requesting continuously, accelerator with 2-cycle latency.
  -> Grant order 0,1,2,3,0,1 over 6 transactions; no CPU's cmd_ready ever asserts while another CPU owns the grant.
- Back-pressure: acc_cmd_ready held 0 for 5 cycles, then req_rsp_ready[owner] held 0 for 4 cycles after rsp_valid.
  -> acc inputs stay stable, state holds in CMD then RSP, and no new grant is issued.
- Same-cycle cmd+rsp handshake: accelerator asserts rsp_valid with cmd_ready in the same cycle.
  -> Owner receives the response that cycle and the state returns to IDLE next cycle.
- Reset mid-RSP: assert reset for 1 cycle while CPU1 owns the grant.
  -> Next cycle all outputs are 0 and state is IDLE.
  -> A pending CPU3 request is granted first after reset (rr_ptr=0, CPU0/1/2 not requesting).
- Withdrawn request: CPU0 drops cmd_valid while in CMD with acc_cmd_ready=0.
  -> Return to IDLE; rr_ptr unchanged; next grant goes to the lowest requesting index ≥0.
